// File: rtl/cal_ctrl.sv
// Sequencing controller for the 4-bit calculator datapath.
// Turns keypad strobes and active-low front-panel buttons into registered
// operands, a one-hot-low operation select, and a latched 8-bit result.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_A    | entering num1, no operator selected
// S_OP   | operator chosen, waiting for the first num2 digit
// S_B    | num2 entered, waiting for equals
// S_EXEC | one-cycle compute; datapath answer captured at its end
// S_RES  | result shown; key restarts, operator chains off res_l
// S_ERR  | invalid operation (div-by-zero or chain overflow); clear only
module cal_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_data,
   input  logic [3:0] op_n,
   input  logic       eq_n,
   input  logic       clr_n,
   input  logic [3:0] ans_h,
   input  logic [3:0] ans_l,
   output logic [3:0] num1,
   output logic [3:0] num2,
   output logic [3:0] select,
   output logic [3:0] res_h,
   output logic [3:0] res_l,
   output logic [1:0] disp_mode,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_OP   = 3'd1,
      S_B    = 3'd2,
      S_EXEC = 3'd3,
      S_RES  = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   localparam logic [3:0] SEL_NONE = 4'b1111;
   localparam logic [3:0] SEL_DIV  = 4'b0111;

   state_t     state_q, state_d;
   logic [3:0] op_prev_q, op_prev_d;
   logic       eq_prev_q, eq_prev_d;
   logic       clr_prev_q, clr_prev_d;
   logic [3:0] num1_q, num1_d;
   logic [3:0] num2_q, num2_d;
   logic [3:0] opc_q, opc_d;
   logic [3:0] sel_q, sel_d;
   logic [3:0] res_h_q, res_h_d;
   logic [3:0] res_l_q, res_l_d;
   logic [1:0] disp_q, disp_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic       clr_ev, eq_ev, op_ev, op_onehot;

   // Button press detection: falling edge against the previous sample.
   // An operator press needs exactly one low bit, and that bit must have fallen.
   always_comb begin
      clr_ev    = clr_prev_q & ~clr_n;
      eq_ev     = eq_prev_q & ~eq_n;
      op_onehot = 1'b0;
      case (op_n)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: op_onehot = 1'b1;
         default:                            op_onehot = 1'b0;
      endcase
      op_ev      = op_onehot & (|(op_prev_q & ~op_n));
      op_prev_d  = op_n;
      eq_prev_d  = eq_n;
      clr_prev_d = clr_n;
   end

   // Next-state and datapath register updates; one event per cycle, clr > eq > op > key.
   always_comb begin
      state_d = state_q;
      num1_d  = num1_q;
      num2_d  = num2_q;
      opc_d   = opc_q;
      res_h_d = res_h_q;
      res_l_d = res_l_q;
      done_d  = 1'b0;
      if (state_q == S_EXEC) begin
         // Events during the compute cycle are dropped, clear included.
         if (opc_q == SEL_DIV && num2_q == 4'd0) begin
            state_d = S_ERR;
         end else begin
            res_h_d = ans_h;
            res_l_d = ans_l;
            done_d  = 1'b1;
            state_d = S_RES;
         end
      end else if (clr_ev) begin
         state_d = S_A;
         num1_d  = 4'd0;
         num2_d  = 4'd0;
         opc_d   = SEL_NONE;
         res_h_d = 4'd0;
         res_l_d = 4'd0;
      end else if (eq_ev) begin
         if (state_q == S_B) state_d = S_EXEC;
      end else if (op_ev) begin
         case (state_q)
            S_A: begin
               opc_d   = op_n;
               num2_d  = 4'd0;
               state_d = S_OP;
            end
            S_OP, S_B: opc_d = op_n;
            S_RES: begin
               if (res_h_q == 4'd0) begin
                  num1_d  = res_l_q;
                  num2_d  = 4'd0;
                  opc_d   = op_n;
                  state_d = S_OP;
               end else begin
                  state_d = S_ERR;
               end
            end
            default: ;
         endcase
      end else if (key_valid) begin
         case (state_q)
            S_A: num1_d = key_data;
            S_OP: begin
               num2_d  = key_data;
               state_d = S_B;
            end
            S_B: num2_d = key_data;
            S_RES: begin
               num1_d  = key_data;
               num2_d  = 4'd0;
               opc_d   = SEL_NONE;
               state_d = S_A;
            end
            default: ;
         endcase
      end
   end

   // Registered outputs decoded from the next state so they align with it.
   always_comb begin
      sel_d  = opc_d;
      disp_d = 2'd1;
      err_d  = 1'b0;
      case (state_d)
         S_A: begin
            sel_d  = SEL_NONE;
            disp_d = 2'd0;
         end
         S_RES: disp_d = 2'd2;
         S_ERR: begin
            sel_d  = SEL_NONE;
            disp_d = 2'd3;
            err_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // All controller state; button history resets low so held buttons need a re-press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_A;
         op_prev_q  <= 4'd0;
         eq_prev_q  <= 1'b0;
         clr_prev_q <= 1'b0;
         num1_q     <= 4'd0;
         num2_q     <= 4'd0;
         opc_q      <= SEL_NONE;
         sel_q      <= SEL_NONE;
         res_h_q    <= 4'd0;
         res_l_q    <= 4'd0;
         disp_q     <= 2'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_prev_q  <= op_prev_d;
         eq_prev_q  <= eq_prev_d;
         clr_prev_q <= clr_prev_d;
         num1_q     <= num1_d;
         num2_q     <= num2_d;
         opc_q      <= opc_d;
         sel_q      <= sel_d;
         res_h_q    <= res_h_d;
         res_l_q    <= res_l_d;
         disp_q     <= disp_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign num1      = num1_q;
   assign num2      = num2_q;
   assign select    = sel_q;
   assign res_h     = res_h_q;
   assign res_l     = res_l_q;
   assign disp_mode = disp_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_cal_ctrl.sv
// Bench for cal_ctrl: directed scenarios followed by random button traffic,
// checked against a transaction-level model through expected-output queues.
module tb_cal_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_data = 4'd0;
   logic [3:0] op_n = 4'hF;
   logic       eq_n = 1'b1;
   logic       clr_n = 1'b1;
   logic [3:0] ans_h, ans_l;
   logic [3:0] num1, num2, select, res_h, res_l;
   logic [1:0] disp_mode;
   logic       done, err;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   cal_ctrl dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_data(key_data),
      .op_n(op_n), .eq_n(eq_n), .clr_n(clr_n), .ans_h(ans_h), .ans_l(ans_l),
      .num1(num1), .num2(num2), .select(select), .res_h(res_h), .res_l(res_l),
      .disp_mode(disp_mode), .done(done), .err(err)
   );

   // Calculator arithmetic as the datapath performs it.
   function automatic logic [7:0] calc(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
      int r;
      case (s)
         4'b1110: r = a + b;
         4'b1101: r = (a >= b) ? a - b : 0;
         4'b1011: r = a * b;
         4'b0111: r = (b == 0) ? 255 : a / b;
         default: r = 0;
      endcase
      return r[7:0];
   endfunction

   always_comb {ans_h, ans_l} = calc(num1, num2, select);

   // Reference model: calculator phases at the level of user-visible behaviour.
   localparam int P_FIRST = 0, P_OPSEL = 1, P_SECOND = 2, P_EXEC = 3, P_SHOWN = 4, P_FAULT = 5;
   int         ph;
   logic [3:0] m_n1, m_n2, m_op;
   logic [7:0] m_res;
   logic       m_done;
   logic [3:0] m_op_p;
   logic       m_eq_p, m_clr_p;

   logic [23:0] exp_q[$];
   logic [7:0]  res_q[$];

   task automatic model_reset();
      ph = P_FIRST; m_n1 = 0; m_n2 = 0; m_op = 4'hF; m_res = 0; m_done = 0;
      m_op_p = 0; m_eq_p = 0; m_clr_p = 0;
   endtask

   function automatic logic [23:0] model_out();
      logic [3:0] s;
      logic [1:0] d;
      s = (ph == P_FIRST || ph == P_FAULT) ? 4'hF : m_op;
      d = (ph == P_FIRST) ? 2'd0 : (ph == P_SHOWN) ? 2'd2 : (ph == P_FAULT) ? 2'd3 : 2'd1;
      return {m_n1, m_n2, s, m_res, d, m_done, ph == P_FAULT};
   endfunction

   task automatic model_step(input logic kv, input logic [3:0] kd, input logic [3:0] op,
                             input logic eq, input logic clr);
      logic ce, ee, oe;
      ce = m_clr_p & ~clr;
      ee = m_eq_p & ~eq;
      oe = ($countones(~op) == 1) && ((m_op_p & ~op) != 4'd0);
      m_clr_p = clr; m_eq_p = eq; m_op_p = op;
      m_done = 0;
      if (ph == P_EXEC) begin
         if (m_op == 4'b0111 && m_n2 == 0) ph = P_FAULT;
         else begin
            m_res = calc(m_n1, m_n2, m_op);
            m_done = 1;
            res_q.push_back(m_res);
            ph = P_SHOWN;
         end
      end else if (ce) begin
         ph = P_FIRST; m_n1 = 0; m_n2 = 0; m_op = 4'hF; m_res = 0;
      end else if (ee) begin
         if (ph == P_SECOND) ph = P_EXEC;
      end else if (oe) begin
         if (ph == P_FIRST) begin m_op = op; m_n2 = 0; ph = P_OPSEL; end
         else if (ph == P_OPSEL || ph == P_SECOND) m_op = op;
         else if (ph == P_SHOWN) begin
            if (m_res[7:4] == 0) begin m_n1 = m_res[3:0]; m_n2 = 0; m_op = op; ph = P_OPSEL; end
            else ph = P_FAULT;
         end
      end else if (kv) begin
         if (ph == P_FIRST) m_n1 = kd;
         else if (ph == P_OPSEL) begin m_n2 = kd; ph = P_SECOND; end
         else if (ph == P_SECOND) m_n2 = kd;
         else if (ph == P_SHOWN) begin m_n1 = kd; m_n2 = 0; m_op = 4'hF; ph = P_FIRST; end
      end
      exp_q.push_back(model_out());
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] dut_out();
      return {num1, num2, select, res_h, res_l, disp_mode, done, err};
   endfunction

   // Monitor: compare every cycle's outputs, and each done pulse against the result queue.
   always @(negedge clk) begin
      if (exp_q.size() > 0) chk("outputs{n1,n2,sel,res,disp,done,err}", dut_out(), exp_q.pop_front());
      if (done === 1'b1) begin
         if (res_q.size() == 0) chk("done_unexpected", 1, 0);
         else chk("done_result", {res_h, res_l}, res_q.pop_front());
      end
   end

   task automatic drive(input logic kv, input logic [3:0] kd, input logic [3:0] op,
                        input logic eq, input logic clr);
      @(negedge clk); #1;
      key_valid = kv; key_data = kd; op_n = op; eq_n = eq; clr_n = clr;
      model_step(kv, kd, op, eq, clr);
   endtask

   task automatic idle();
      drive(0, 4'd0, 4'hF, 1, 1);
   endtask

   task automatic key(input logic [3:0] d);
      drive(1, d, 4'hF, 1, 1);
   endtask

   task automatic op_press(input logic [3:0] op);
      drive(0, 4'd0, op, 1, 1);
      idle();
   endtask

   task automatic eq_press();
      drive(0, 4'd0, 4'hF, 0, 1);
   endtask

   task automatic clear();
      drive(0, 4'd0, 4'hF, 1, 0);
      idle();
   endtask

   localparam logic [23:0] RST_VEC = {4'h0, 4'h0, 4'hF, 8'h00, 2'd0, 1'b0, 1'b0};

   initial begin
      // Buttons held low through reset must not produce events afterwards.
      model_reset();
      op_n = 4'b1110; eq_n = 0; clr_n = 0;
      #12 chk("reset_values", dut_out(), RST_VEC);
      @(negedge clk); #1 rst_n = 1;
      drive(0, 4'd0, 4'b1110, 0, 0);
      drive(0, 4'd0, 4'b1110, 0, 0);
      idle();
      idle();
      chk("held_through_reset", {disp_mode, select}, {2'd0, 4'hF});

      // Add
      key(3); op_press(4'b1110); key(5); eq_press(); idle(); idle();
      chk("add_res", {res_h, res_l, select, disp_mode, done}, {8'h08, 4'b1110, 2'd2, 1'b1});
      idle();
      chk("add_done_width", done, 0);

      // Sub underflow
      clear(); key(2); op_press(4'b1101); key(7); eq_press(); idle(); idle();
      chk("sub_underflow", {res_h, res_l, err, done}, {8'h00, 1'b0, 1'b1});

      // Chain
      clear(); key(4); op_press(4'b1011); key(3); eq_press(); idle(); idle();
      chk("mul_res", {res_h, res_l}, 8'h0C);
      op_press(4'b1101);
      chk("chain_op", {num1, num2, select, disp_mode}, {4'hC, 4'h0, 4'b1101, 2'd1});
      key(5); eq_press(); idle(); idle();
      chk("chain_res", {res_h, res_l}, 8'h07);

      // Overflow chain
      clear(); key(4'hF); op_press(4'b1011); key(4'hF); eq_press(); idle(); idle();
      chk("mul_ff", {res_h, res_l}, 8'hE1);
      op_press(4'b1110);
      chk("overflow_err", {err, disp_mode, select}, {1'b1, 2'd3, 4'hF});
      key(1); idle();
      chk("err_ignores_key", {num1, err}, {4'hF, 1'b1});
      clear();
      chk("clear_from_err", dut_out(), RST_VEC);

      // Div by zero
      key(9); op_press(4'b0111); key(0); eq_press(); idle(); idle();
      chk("div_zero", {err, res_h, res_l, done, disp_mode}, {1'b1, 8'h00, 1'b0, 2'd3});
      clear();

      // Clear and equals in the same cycle
      key(1); op_press(4'b1110); key(2); drive(0, 4'd0, 4'hF, 0, 0); idle(); idle();
      chk("clr_beats_eq", {disp_mode, done, num1}, {2'd0, 1'b0, 4'h0});

      // Two operator bits falling together
      key(6); drive(0, 4'd0, 4'b1100, 1, 1); idle();
      chk("op_two_bits", {disp_mode, select, num1}, {2'd0, 4'hF, 4'h6});

      // Reset during the compute cycle
      key(1); op_press(4'b1110); key(2); eq_press();
      @(negedge clk); #1;
      key_valid = 0; op_n = 4'hF; eq_n = 1; clr_n = 1;
      chk("in_exec_before_reset", disp_mode, 2'd1);
      rst_n = 0;
      #1 chk("reset_in_exec", dut_out(), RST_VEC);
      model_reset();
      @(negedge clk); #1 rst_n = 1;
      idle();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic       kv, eq, clr;
         logic [3:0] kd, op;
         int         r;
         kv = ($urandom_range(0, 9) < 3);
         kd = 4'($urandom_range(0, 15));
         r  = $urandom_range(0, 9);
         if (r < 2)       op = ~(4'b0001 << $urandom_range(0, 3));
         else if (r == 2) op = 4'($urandom_range(0, 15));
         else             op = 4'hF;
         eq  = ($urandom_range(0, 5) != 0);
         clr = ($urandom_range(0, 24) != 0);
         drive(kv, kd, op, eq, clr);
      end
      idle();
      idle();
      @(negedge clk); #1;
      chk("queue_drained", exp_q.size(), 0);
      chk("results_drained", res_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
